// File: rtl/hand_datapath.sv
// hand_datapath
// -------------
// Card-dealing datapath that sits behind the baccarat sequencing state
// machine. A free-running card source cycles through ranks 1..13. When
// exactly one load strobe is high, the addressed empty slot captures the
// rank the source held before the edge. The six slots drive the rank
// outputs and two combinational hand scores, which feed back to the
// state machine.
//
// All state changes happen on the falling edge of slow_clock.
//
// Ports
//   slow_clock              in   block clock (falling-edge active)
//   resetb                  in   synchronous reset, active high
//   new_hand                in   synchronous clear of slots and error flags
//   load_pcard1..3          in   player slot load strobes
//   load_dcard1..3          in   dealer slot load strobes
//   pcard1..3, dcard1..3    out  slot ranks, 0 = empty, 1..13 = A..K
//   pscore, dscore          out  hand scores 0..9
//   cards_dealt             out  number of occupied slots 0..6
//   err                     out  sticky flags: [0] multi-load, [1] overwrite
module hand_datapath #(
    parameter logic [3:0] CARD_SEED = 4'd1
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       new_hand,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic [1:0] err
);

    // Slot order in the packed arrays: 0..2 = player 1..3, 3..5 = dealer 1..3.
    logic [5:0][3:0] slot_q;
    logic [5:0][3:0] slot_d;
    logic [3:0]      counter_q;
    logic [3:0]      counter_d;
    logic [2:0]      dealt_q;
    logic [2:0]      dealt_d;
    logic [1:0]      err_q;
    logic [1:0]      err_d;
    logic [5:0]      strobe_s;
    logic [2:0]      strobe_cnt_s;

    // Baccarat value of a rank: tens and faces (and empty slots) count 0.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank <= 4'd9) begin
            return rank;
        end else begin
            return 4'd0;
        end
    endfunction

    // Hand score: sum of three values mod 10. The raw sum is at most 27,
    // so a single subtraction of 10 or 20 replaces a divider.
    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] sum;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
        if (sum >= 5'd20) begin
            sum = sum - 5'd20;
        end else if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end else begin
            sum = sum;
        end
        return sum[3:0];
    endfunction

    // Number of strobes raised in the current cycle.
    function automatic logic [2:0] strobe_count(input logic [5:0] s);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 6; i++) begin
            c = c + {2'b00, s[i]};
        end
        return c;
    endfunction

    assign strobe_s = {load_dcard3, load_dcard2, load_dcard1,
                       load_pcard3, load_pcard2, load_pcard1};
    assign strobe_cnt_s = strobe_count(strobe_s);

    // Next-state logic: card source, slot capture, occupancy and error flags.
    always_comb begin
        slot_d  = slot_q;
        dealt_d = dealt_q;
        err_d   = err_q;

        // Legal ranks step by one and 13 wraps to 1; any illegal encoding
        // (0, 14, 15) also recovers to 1.
        if ((counter_q >= 4'd1) && (counter_q <= 4'd12)) begin
            counter_d = counter_q + 4'd1;
        end else begin
            counter_d = 4'd1;
        end

        if (resetb) begin
            counter_d = CARD_SEED;
            slot_d    = '0;
            dealt_d   = 3'd0;
            err_d     = 2'b00;
        end else if (new_hand) begin
            // Counter keeps running across hands; strobes are ignored.
            slot_d  = '0;
            dealt_d = 3'd0;
            err_d   = 2'b00;
        end else if (strobe_cnt_s > 3'd1) begin
            err_d[0] = 1'b1;
        end else if (strobe_cnt_s == 3'd1) begin
            for (int i = 0; i < 6; i++) begin
                if (strobe_s[i]) begin
                    if (slot_q[i] != 4'd0) begin
                        err_d[1] = 1'b1;
                    end else begin
                        slot_d[i] = counter_q;
                        dealt_d   = dealt_q + 3'd1;
                    end
                end else begin
                    slot_d[i] = slot_d[i];
                end
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // State registers, updated on the falling edge of the block clock.
    always_ff @(negedge slow_clock) begin
        counter_q <= counter_d;
        slot_q    <= slot_d;
        dealt_q   <= dealt_d;
        err_q     <= err_d;
    end

    assign pcard1      = slot_q[0];
    assign pcard2      = slot_q[1];
    assign pcard3      = slot_q[2];
    assign dcard1      = slot_q[3];
    assign dcard2      = slot_q[4];
    assign dcard3      = slot_q[5];
    assign pscore      = hand_score(slot_q[0], slot_q[1], slot_q[2]);
    assign dscore      = hand_score(slot_q[3], slot_q[4], slot_q[5]);
    assign cards_dealt = dealt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hand_datapath.sv
// Bench for hand_datapath: directed deals with a reference model of the
// dealing rules, checked every rising edge, plus hand-computed literals.
module tb_hand_datapath;

    localparam int SEED = 1;

    logic       slow_clock;
    logic       resetb;
    logic       new_hand;
    logic [5:0] ld;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic [2:0] cards_dealt;
    logic [1:0] err;

    int n_vec;
    int n_bad;

    // Reference model state
    int  m_card;
    int  m_slot [6];
    int  m_err0, m_err1;
    bit  m_valid;
    int  m_nstrobe;

    hand_datapath #(.CARD_SEED(4'd1)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .new_hand   (new_hand),
        .load_pcard1(ld[0]),
        .load_pcard2(ld[1]),
        .load_pcard3(ld[2]),
        .load_dcard1(ld[3]),
        .load_dcard2(ld[4]),
        .load_dcard3(ld[5]),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .cards_dealt(cards_dealt),
        .err        (err)
    );

    initial begin
        slow_clock = 1'b1;
        forever #5 slow_clock = ~slow_clock;
    end

    function automatic int val(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    // Model: applies the dealing rules at each falling edge.
    always @(negedge slow_clock) begin
        m_nstrobe = 0;
        for (int i = 0; i < 6; i++) m_nstrobe += int'(ld[i]);
        if (resetb === 1'b1) begin
            m_card  = SEED;
            for (int i = 0; i < 6; i++) m_slot[i] = 0;
            m_err0  = 0;
            m_err1  = 0;
            m_valid = 1'b1;
        end else begin
            if (new_hand) begin
                for (int i = 0; i < 6; i++) m_slot[i] = 0;
                m_err0 = 0;
                m_err1 = 0;
            end else if (m_nstrobe >= 2) begin
                m_err0 = 1;
            end else if (m_nstrobe == 1) begin
                for (int i = 0; i < 6; i++)
                    if (ld[i]) begin
                        if (m_slot[i] != 0) m_err1 = 1;
                        else m_slot[i] = m_card;
                    end
            end
            m_card = (m_card % 13) + 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Compare process: every rising edge, DUT outputs against the model.
    always @(posedge slow_clock) begin
        if (m_valid) begin
            int ps, ds, nd;
            ps = (val(m_slot[0]) + val(m_slot[1]) + val(m_slot[2])) % 10;
            ds = (val(m_slot[3]) + val(m_slot[4]) + val(m_slot[5])) % 10;
            nd = 0;
            for (int i = 0; i < 6; i++) if (m_slot[i] != 0) nd++;
            cmp("m_pcard1", int'(pcard1), m_slot[0]);
            cmp("m_pcard2", int'(pcard2), m_slot[1]);
            cmp("m_pcard3", int'(pcard3), m_slot[2]);
            cmp("m_dcard1", int'(dcard1), m_slot[3]);
            cmp("m_dcard2", int'(dcard2), m_slot[4]);
            cmp("m_dcard3", int'(dcard3), m_slot[5]);
            cmp("m_pscore", int'(pscore), ps);
            cmp("m_dscore", int'(dscore), ds);
            cmp("m_dealt",  int'(cards_dealt), nd);
            cmp("m_err",    int'(err), m_err1 * 2 + m_err0);
        end
    end

    // One falling edge with the given inputs; returns just after the edge.
    task automatic edge_in(input logic r, input logic nh, input logic [5:0] s);
        @(posedge slow_clock);
        resetb   = r;
        new_hand = nh;
        ld       = s;
        @(negedge slow_clock);
        #1;
        resetb   = 1'b0;
        new_hand = 1'b0;
        ld       = 6'b000000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_in(1'b0, 1'b0, 6'b000000);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        m_valid  = 1'b0;
        resetb   = 1'b1;
        new_hand = 1'b0;
        ld       = 6'b000000;

        // Deal in order after a two-edge reset
        edge_in(1'b1, 1'b0, 6'b000000);
        edge_in(1'b1, 1'b0, 6'b000000);
        cmp("rst_dealt", int'(cards_dealt), 0);
        cmp("rst_err",   int'(err), 0);
        edge_in(1'b0, 1'b0, 6'b000001);
        edge_in(1'b0, 1'b0, 6'b001000);
        edge_in(1'b0, 1'b0, 6'b000010);
        edge_in(1'b0, 1'b0, 6'b010000);
        cmp("s1_pcard1", int'(pcard1), 1);
        cmp("s1_dcard1", int'(dcard1), 2);
        cmp("s1_pcard2", int'(pcard2), 3);
        cmp("s1_dcard2", int'(dcard2), 4);
        cmp("s1_pscore", int'(pscore), 4);
        cmp("s1_dscore", int'(dscore), 6);
        cmp("s1_dealt",  int'(cards_dealt), 4);
        cmp("s1_err",    int'(err), 0);

        // new_hand beats a simultaneous strobe; counter keeps running (5 -> 6)
        edge_in(1'b0, 1'b1, 6'b100000);
        cmp("nh_dcard3", int'(dcard3), 0);
        cmp("nh_pcard1", int'(pcard1), 0);
        cmp("nh_dealt",  int'(cards_dealt), 0);
        cmp("nh_err",    int'(err), 0);
        edge_in(1'b0, 1'b0, 6'b000001);
        cmp("nh_cont",   int'(pcard1), 6);

        // Wrap and face cards
        edge_in(1'b1, 1'b0, 6'b000000);
        idle(12);
        edge_in(1'b0, 1'b0, 6'b000001);
        edge_in(1'b0, 1'b0, 6'b000010);
        cmp("wr_pcard1", int'(pcard1), 13);
        cmp("wr_pcard2", int'(pcard2), 1);
        cmp("wr_pscore", int'(pscore), 1);

        // Mod-10 scoring: 7 + 8 + 9
        edge_in(1'b1, 1'b0, 6'b000000);
        idle(6);
        edge_in(1'b0, 1'b0, 6'b000001);
        edge_in(1'b0, 1'b0, 6'b000010);
        edge_in(1'b0, 1'b0, 6'b000100);
        cmp("md_pcard3", int'(pcard3), 9);
        cmp("md_pscore", int'(pscore), 4);

        // Multi-load, then overwrite
        edge_in(1'b1, 1'b0, 6'b000000);
        edge_in(1'b0, 1'b0, 6'b001001);
        cmp("ml_pcard1", int'(pcard1), 0);
        cmp("ml_dcard1", int'(dcard1), 0);
        cmp("ml_err",    int'(err), 1);
        edge_in(1'b0, 1'b0, 6'b000001);
        cmp("ml_adv",    int'(pcard1), 2);
        edge_in(1'b0, 1'b0, 6'b000001);
        cmp("ow_pcard1", int'(pcard1), 2);
        cmp("ow_err",    int'(err), 3);
        cmp("ow_dealt",  int'(cards_dealt), 1);

        // Reset mid-hand with 5 cards and err=10
        edge_in(1'b1, 1'b0, 6'b000000);
        edge_in(1'b0, 1'b0, 6'b000001);
        edge_in(1'b0, 1'b0, 6'b001000);
        edge_in(1'b0, 1'b0, 6'b000010);
        edge_in(1'b0, 1'b0, 6'b010000);
        edge_in(1'b0, 1'b0, 6'b000100);
        edge_in(1'b0, 1'b0, 6'b000001);
        cmp("mr_dealt5", int'(cards_dealt), 5);
        cmp("mr_err10",  int'(err), 2);
        edge_in(1'b1, 1'b0, 6'b100000);
        cmp("mr_dcard3", int'(dcard3), 0);
        cmp("mr_pcard1", int'(pcard1), 0);
        cmp("mr_dealt",  int'(cards_dealt), 0);
        cmp("mr_err",    int'(err), 0);
        cmp("mr_pscore", int'(pscore), 0);
        edge_in(1'b0, 1'b0, 6'b000001);
        cmp("mr_seed",   int'(pcard1), 1);

        @(posedge slow_clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hand_datapath.md
Name: hand_datapath

Overview:
- Card-dealing datapath directly downstream of the baccarat sequencing state machine.
- Consumes the six one-hot load strobes and deals a card into the addressed slot from an internal free-running card source.
- Holds the six card registers and produces pscore, dscore and pcard3, which feed back to the state machine.
- Card ranks also go out to the seven-segment display logic.

Parameters:
- CARD_SEED, 1: reset value of the card source counter; legal range 1..13.

Ports:
- slow_clock  input  1  block clock; all state updates on the falling edge.
- resetb  input  1  synchronous reset, active-high (1 = reset), sampled on the slow_clock falling edge.
- new_hand  input  1  synchronous clear of all card slots and error flags.
- load_pcard1, load_pcard2, load_pcard3  input  1 each  player slot load strobes.
- load_dcard1, load_dcard2, load_dcard3  input  1 each  dealer slot load strobes.
- pcard1, pcard2, pcard3  output  4 each  player card ranks; 0 = empty, 1..13 = A..K.
- dcard1, dcard2, dcard3  output  4 each  dealer card ranks, same encoding.
- pscore, dscore  output  4 each  hand scores, 0..9.
- cards_dealt  output  3  number of occupied slots, 0..6.
- err  output  2  sticky flags: [0] multi-load, [1] overwrite.

Behaviour:
- Card source:
  - 4-bit counter advances on every falling edge, including edges where a load occurs.
  - Counts 1,2,…,13,1 (13 wraps to 1); never holds 0 or 14..15.
- Reset (resetb=1 at an edge):
  - Counter = CARD_SEED.
  - All six slots = 0; cards_dealt = 0; err = 2'b00.
  - Load strobes and new_hand are ignored.
  - Reset mid-hand discards all dealt cards.
- Load (exactly one strobe high, slot empty, no reset, no new_hand):
  - Slot captures the counter value present before the edge, i.e. the pre-increment value.
  - Slot becomes occupied; cards_dealt increments by 1.
  - Slot visible on outputs immediately after the edge.
- Multi-load (two or more strobes high in one cycle):
  - No slot changes; err[0] set; counter still advances.
- Overwrite (one strobe high, addressed slot already nonzero):
  - Slot unchanged; err[1] set; cards_dealt unchanged.
- new_hand=1 (no reset):
  - Slots, cards_dealt and err cleared.
  - Counter keeps running and is not reloaded.
  - new_hand takes priority over any simultaneous strobe; the strobe is ignored and no err is set.
- Errors are sticky until reset or new_hand.
- Score arithmetic (combinational from the slot registers, zero added latency):
  - Card value = rank for 1..9; 0 for 10..13 and for empty slots.
  - pscore = (value(pcard1) + value(pcard2) + value(pcard3)) mod 10.
  - dscore is the same over the dcard slots.
  - Maximum raw sum is 27; use a 5-bit intermediate and reduce by subtracting 10 or 20.
- Outputs: pcard3 is the raw rank (0 while empty), which the state machine uses for third-card rules.
- No latches; unused counter encodings (0, 14, 15), if ever reached, return to 1 on the next edge.

Test Plan:
- Reset, then deal in order: hold resetb=1 for 2 edges, release, assert load_pcard1 on the 1st edge, load_dcard1 on the 2nd, load_pcard2 on the 3rd, load_dcard2 on the 4th.
  -> pcard1=1, dcard1=2, pcard2=3, dcard2=4; pscore=4, dscore=6; cards_dealt=4; err=00.
- Wrap and face cards: after reset, idle 12 edges, then load_pcard1, then load_pcard2.
  -> pcard1=13, pcard2=1 (counter wrapped); pscore=1.
- Mod-10 scoring: after reset, idle 6 edges, load_pcard1 (rank 7); next edge load_pcard2 (rank 8); next edge load_pcard3 (rank 9).
  -> pscore = 24 mod 10 = 4; pcard3=9.
- Error handling:
  - load_pcard1 and load_dcard1 high together -> both slots stay 0; err=01; counter still advances.
  - Later, load_pcard1 twice -> first load captures; second leaves the value unchanged; err=11.
- new_hand priority: with 4 cards dealt, assert new_hand and load_dcard3 together.
  -> all slots 0; cards_dealt=0; err=00; dcard3=0.
  - Next load_pcard1 captures the continuing counter value, not CARD_SEED.
- Reset mid-hand: with 5 cards dealt and err=10, assert resetb with load_dcard3.
  -> all outputs 0; counter back to CARD_SEED; dcard3 stays 0.
